// File: rtl/lbist_pkg.sv
//------------------------------------------------------------------------------
// Module : lbist_pkg
// Brief  : Shared state encoding and counter-width helper for the LBIST response analyser.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_INC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Bits needed to hold any value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lbist_cmp.sv
//------------------------------------------------------------------------------
// Module : lbist_cmp
// Brief  : XOR-reduce comparator of faulty vs fault-free CUT outputs, registered flag.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lbist_cmp #(
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [OUT_BITS-1:0] cut_i,
    input  logic [OUT_BITS-1:0] ff_i,
    output logic                mm_o,
    output logic                mismatch_o
);

    logic mismatch_q;

    assign mm_o       = |(cut_i ^ ff_i);
    assign mismatch_o = mismatch_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mismatch_q <= 1'b0;
        end else if (clr_i) begin
            mismatch_q <= 1'b0;
        end else if (en_i) begin
            mismatch_q <= mm_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/lbist_resp_analyzer.sv
//------------------------------------------------------------------------------
// Module : lbist_resp_analyzer
// Brief  : Sequences the fault list, compares CUT responses and keeps detection bitmap/count.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lbist_resp_analyzer
    import lbist_pkg::*;
#(
    parameter int OUT_BITS       = 2,
    parameter int NUM_FAULTS     = 22,
    parameter int PATS_PER_FAULT = 31,
    parameter int EARLY_DROP     = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [OUT_BITS-1:0]                 CUT_OP,
    input  logic [OUT_BITS-1:0]                 FF_OP,
    output logic                                pat_en,
    output logic                                FIL_INC,
    output logic                                busy,
    output logic                                done,
    output logic [cnt_width(NUM_FAULTS)-1:0]    fault_idx,
    output logic [NUM_FAULTS-1:0]               det_vec,
    output logic [cnt_width(NUM_FAULTS)-1:0]    det_cnt,
    output logic                                mismatch
);

    localparam int IDX_W = cnt_width(NUM_FAULTS);
    localparam int PAT_W = cnt_width(PATS_PER_FAULT);
    localparam logic [PAT_W-1:0] LAST_PAT   = PAT_W'(PATS_PER_FAULT - 1);
    localparam logic [IDX_W-1:0] LAST_FAULT = IDX_W'(NUM_FAULTS - 1);

    state_e                  state_q;
    logic [PAT_W-1:0]        pat_cnt_q;
    logic [IDX_W-1:0]        fault_idx_q;
    logic [NUM_FAULTS-1:0]   det_vec_q;
    logic [IDX_W-1:0]        det_cnt_q;
    logic                    pat_en_q;
    logic                    fil_inc_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    mm;
    logic [NUM_FAULTS-1:0]   det_sel;
    logic                    new_det;
    logic                    go_inc;
    logic [NUM_FAULTS-1:0]   det_vec_d;

    lbist_cmp #(
        .OUT_BITS (OUT_BITS)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .clr_i      ((state_q == ST_IDLE) && start),
        .en_i       (state_q == ST_RUN),
        .cut_i      (CUT_OP),
        .ff_i       (FF_OP),
        .mm_o       (mm),
        .mismatch_o (mismatch)
    );

    // Only a fault's first detection moves the count, so repeats are harmless.
    assign det_sel   = NUM_FAULTS'(1) << fault_idx_q;
    assign new_det   = mm && ((det_vec_q & det_sel) == '0);
    assign det_vec_d = det_vec_q | det_sel;
    assign go_inc    = (mm && (EARLY_DROP != 0)) || (pat_cnt_q == LAST_PAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pat_cnt_q   <= '0;
            fault_idx_q <= '0;
            det_vec_q   <= '0;
            det_cnt_q   <= '0;
            pat_en_q    <= 1'b0;
            fil_inc_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_RUN;
                        pat_cnt_q   <= '0;
                        fault_idx_q <= '0;
                        det_vec_q   <= '0;
                        det_cnt_q   <= '0;
                        pat_en_q    <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    pat_cnt_q <= pat_cnt_q + 1'b1;
                    if (new_det) begin
                        det_vec_q <= det_vec_d;
                        det_cnt_q <= det_cnt_q + 1'b1;
                    end
                    if (go_inc) begin
                        state_q   <= ST_INC;
                        pat_en_q  <= 1'b0;
                        fil_inc_q <= 1'b1;
                    end
                end
                ST_INC: begin
                    fil_inc_q <= 1'b0;
                    pat_cnt_q <= '0;
                    if (fault_idx_q == LAST_FAULT) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= ST_RUN;
                        fault_idx_q <= fault_idx_q + 1'b1;
                        pat_en_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_DONE;
                end
            endcase
        end
    end

    assign pat_en    = pat_en_q;
    assign FIL_INC   = fil_inc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault_idx = fault_idx_q;
    assign det_vec   = det_vec_q;
    assign det_cnt   = det_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lbist_resp_analyzer.sv
//------------------------------------------------------------------------------
// Module : tb_lbist_resp_analyzer
// Brief  : Directed bench: early-drop instance (a) and full-pattern instance (b), 3 faults x 4 patterns.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lbist_resp_analyzer;

    localparam int NF = 3;
    localparam int PP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] ff_op;
    logic [1:0] cut_a;
    logic [1:0] cut_b;

    logic       pat_en_a, fil_a, busy_a, done_a, mm_a;
    logic [1:0] fidx_a, cnt_a;
    logic [2:0] det_a;
    logic       pat_en_b, fil_b, busy_b, done_b, mm_b;
    logic [1:0] fidx_b, cnt_b;
    logic [2:0] det_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lbist_resp_analyzer #(
        .OUT_BITS(2), .NUM_FAULTS(NF), .PATS_PER_FAULT(PP), .EARLY_DROP(1)
    ) u_a (
        .clk(clk), .rst(rst), .start(start), .CUT_OP(cut_a), .FF_OP(ff_op),
        .pat_en(pat_en_a), .FIL_INC(fil_a), .busy(busy_a), .done(done_a),
        .fault_idx(fidx_a), .det_vec(det_a), .det_cnt(cnt_a), .mismatch(mm_a)
    );

    lbist_resp_analyzer #(
        .OUT_BITS(2), .NUM_FAULTS(NF), .PATS_PER_FAULT(PP), .EARLY_DROP(0)
    ) u_b (
        .clk(clk), .rst(rst), .start(start), .CUT_OP(cut_b), .FF_OP(ff_op),
        .pat_en(pat_en_b), .FIL_INC(fil_b), .busy(busy_b), .done(done_b),
        .fault_idx(fidx_b), .det_vec(det_b), .det_cnt(cnt_b), .mismatch(mm_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_a"}, 32'({pat_en_a, fil_a, busy_a, done_a, fidx_a, det_a, cnt_a, mm_a}), 32'd0);
        chk({tag, "_b"}, 32'({pat_en_b, fil_b, busy_b, done_b, fidx_b, det_b, cnt_b, mm_b}), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Leaves the bench in cycle t=0: the first RUN cycle of fault 0.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b1;
        ff_op = 2'b00;
        cut_a = 2'b00;
        cut_b = 2'b00;

        // Reset held with start asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cleared($sformatf("reset_%0d", i));
        end
        start = 1'b0;
        rst   = 1'b1;
        tick();
        chk_cleared("idle_after_reset");

        // Clean run: 4 patterns + 1 INC per fault, done 15 cycles after start.
        do_start();
        for (int t = 0; t <= 15; t++) begin
            chk($sformatf("clean_pat_en_a_t%0d", t), 32'(pat_en_a), 32'((t < 15) && (t % 5 != 4)));
            chk($sformatf("clean_fil_a_t%0d", t),    32'(fil_a),    32'((t < 15) && (t % 5 == 4)));
            chk($sformatf("clean_busy_a_t%0d", t),   32'(busy_a),   32'(t < 15));
            chk($sformatf("clean_done_a_t%0d", t),   32'(done_a),   32'(t >= 15));
            chk($sformatf("clean_fidx_a_t%0d", t),   32'(fidx_a),   (t < 15) ? 32'(t / 5) : 32'd2);
            chk($sformatf("clean_fil_b_t%0d", t),    32'(fil_b),    32'((t < 15) && (t % 5 == 4)));
            chk($sformatf("clean_done_b_t%0d", t),   32'(done_b),   32'(t >= 15));
            tick();
        end
        chk("clean_det_a", 32'(det_a), 32'd0);
        chk("clean_cnt_a", 32'(cnt_a), 32'd0);
        chk("clean_det_b", 32'(det_b), 32'd0);
        chk("clean_cnt_b", 32'(cnt_b), 32'd0);

        // Start in DONE is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_ignored_done", 32'(done_a), 32'd1);
        chk("done_start_ignored_busy", 32'(busy_a), 32'd0);

        // Mismatch on fault 1 pattern 2 (t=7); b also repeats it on pattern 3 (t=8).
        do_reset();
        do_start();
        for (int t = 0; t <= 15; t++) begin
            cut_a = (t == 7) ? 2'b01 : 2'b00;
            cut_b = (t == 7 || t == 8) ? 2'b10 : 2'b00;
            if (t == 7) begin
                chk("ed_det_a_t7", 32'(det_a), 32'd0);
            end
            if (t == 8) begin
                chk("ed_det_a_t8",    32'(det_a),    32'b010);
                chk("ed_cnt_a_t8",    32'(cnt_a),    32'd1);
                chk("ed_fil_a_t8",    32'(fil_a),    32'd1);
                chk("ed_pat_en_a_t8", 32'(pat_en_a), 32'd0);
                chk("ed_mm_a_t8",     32'(mm_a),     32'd1);
                chk("full_det_b_t8",  32'(det_b),    32'b010);
                chk("full_cnt_b_t8",  32'(cnt_b),    32'd1);
                chk("full_pat_en_b_t8", 32'(pat_en_b), 32'd1);
                chk("full_fil_b_t8",  32'(fil_b),    32'd0);
            end
            if (t == 9) begin
                chk("ed_pat_en_a_t9", 32'(pat_en_a), 32'd1);
                chk("ed_fidx_a_t9",   32'(fidx_a),   32'd2);
                chk("full_fil_b_t9",  32'(fil_b),    32'd1);
                chk("full_cnt_b_t9",  32'(cnt_b),    32'd1);
                chk("full_mm_b_t9",   32'(mm_b),     32'd1);
            end
            if (t == 13) begin
                chk("ed_done_a_t13", 32'(done_a), 32'd0);
            end
            if (t == 14) begin
                chk("ed_done_a_t14",  32'(done_a), 32'd1);
                chk("ed_busy_a_t14",  32'(busy_a), 32'd0);
                chk("full_fil_b_t14", 32'(fil_b),  32'd1);
                chk("full_done_b_t14", 32'(done_b), 32'd0);
            end
            if (t == 15) begin
                chk("ed_det_a_end",   32'(det_a),  32'b010);
                chk("ed_cnt_a_end",   32'(cnt_a),  32'd1);
                chk("full_done_b_t15", 32'(done_b), 32'd1);
                chk("full_det_b_end", 32'(det_b),  32'b010);
                chk("full_cnt_b_end", 32'(cnt_b),  32'd1);
            end
            tick();
        end
        cut_a = 2'b00;
        cut_b = 2'b00;

        // Mismatch only on the last pattern of the last fault (t=13).
        do_reset();
        do_start();
        for (int t = 0; t <= 15; t++) begin
            cut_a = (t == 13) ? 2'b11 : 2'b00;
            cut_b = (t == 13) ? 2'b11 : 2'b00;
            if (t == 13) begin
                chk("last_det_a_t13", 32'(det_a), 32'd0);
            end
            if (t == 14) begin
                chk("last_det_a_t14",  32'(det_a),  32'b100);
                chk("last_cnt_a_t14",  32'(cnt_a),  32'd1);
                chk("last_fil_a_t14",  32'(fil_a),  32'd1);
                chk("last_done_a_t14", 32'(done_a), 32'd0);
                chk("last_mm_a_t14",   32'(mm_a),   32'd1);
                chk("last_det_b_t14",  32'(det_b),  32'b100);
            end
            if (t == 15) begin
                chk("last_done_a_t15", 32'(done_a), 32'd1);
                chk("last_busy_a_t15", 32'(busy_a), 32'd0);
                chk("last_det_a_t15",  32'(det_a),  32'b100);
                chk("last_done_b_t15", 32'(done_b), 32'd1);
                chk("last_cnt_b_t15",  32'(cnt_b),  32'd1);
            end
            tick();
        end
        cut_a = 2'b00;
        cut_b = 2'b00;

        // Start pulse mid-RUN is ignored; reset at fault 1 clears everything.
        do_reset();
        do_start();
        for (int t = 0; t <= 6; t++) begin
            start = (t == 2);
            cut_b = (t == 5) ? 2'b01 : 2'b00;
            if (t == 3) begin
                chk("mid_fidx_a_t3",   32'(fidx_a),   32'd0);
                chk("mid_pat_en_a_t3", 32'(pat_en_a), 32'd1);
                chk("mid_busy_b_t3",   32'(busy_b),   32'd1);
            end
            if (t == 4) begin
                chk("mid_fil_a_t4", 32'(fil_a), 32'd1);
                chk("mid_fil_b_t4", 32'(fil_b), 32'd1);
            end
            if (t == 6) begin
                chk("mid_fidx_a_t6", 32'(fidx_a), 32'd1);
                chk("mid_det_b_t6",  32'(det_b),  32'b010);
                chk("mid_cnt_b_t6",  32'(cnt_b),  32'd1);
                chk("mid_cnt_a_t6",  32'(cnt_a),  32'd0);
                rst = 1'b0;
            end
            tick();
        end
        cut_b = 2'b00;
        chk_cleared("mid_reset");
        rst = 1'b1;
        tick();
        chk_cleared("mid_reset_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
